// File: rtl/cic_interp_pkg.sv
// Shared CIC interpolator definitions: default widths, the I/Q sample type and rate sanitising.
// Imported by the comb, upsample and integrator stages so they agree on sample layout.
package cic_interp_pkg;

    localparam int CIC_WIDTH    = 16;
    localparam int CIC_MAX_RATE = 16;

    typedef struct packed {
        logic [CIC_WIDTH-1:0] inph;
        logic [CIC_WIDTH-1:0] quad;
    } iq_sample_t;

    // A zero ratio would stall the phase counter, so it is treated as pass-through.
    function automatic int unsigned sanitize_rate(input int unsigned rate,
                                                  input int unsigned max_rate);
        if (rate == 0) begin
            return 1;
        end
        if (rate > max_rate) begin
            return max_rate;
        end
        return rate;
    endfunction

endpackage

// File: rtl/cic_phase_counter.sv
// Low-rate phase counter: tracks phase within a frame and latches the sanitised rate at wrap.
// Wrap strobe is combinational from phase and i_enable; it holds state whenever i_enable is low.
module cic_phase_counter
    import cic_interp_pkg::*;
#(
    parameter  int MAX_RATE = CIC_MAX_RATE,
    localparam int RATE_W   = $clog2(MAX_RATE + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [RATE_W-1:0] i_rate,
    output logic [RATE_W-1:0] o_phase,
    output logic              o_wrap
);

    logic [RATE_W-1:0] phase_q, phase_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [RATE_W-1:0] rate_eff;
    logic              last_phase;

    assign rate_eff   = RATE_W'(sanitize_rate(32'(i_rate), MAX_RATE));
    assign last_phase = (phase_q == rate_q - RATE_W'(1));

    always_comb begin
        phase_d = phase_q;
        rate_d  = rate_q;
        if (i_enable) begin
            // New rate is only picked up at a frame boundary so frames are never truncated.
            if (last_phase) begin
                phase_d = '0;
                rate_d  = rate_eff;
            end else begin
                phase_d = phase_q + RATE_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            phase_q <= '0;
            rate_q  <= rate_eff;
        end else begin
            phase_q <= phase_d;
            rate_q  <= rate_d;
        end
    end

    assign o_phase = phase_q;
    assign o_wrap  = i_enable & last_phase & ~i_reset;

endmodule

// File: rtl/cic_interp_upsample.sv
// CIC rate expander: turns each comb sample into RATE high-rate samples (zero-stuff or hold).
// Latency 1 clock comb-to-output; stalls with i_enable low, comb advanced via o_comb_ready.
module cic_interp_upsample
    import cic_interp_pkg::*;
#(
    parameter  int WIDTH     = CIC_WIDTH,
    parameter  int MAX_RATE  = CIC_MAX_RATE,
    parameter  int HOLD_MODE = 0,
    localparam int RATE_W    = $clog2(MAX_RATE + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_comb_ready,
    input  logic [WIDTH-1:0]  i_inph_data,
    input  logic [WIDTH-1:0]  i_quad_data,
    output logic [WIDTH-1:0]  o_inph_data,
    output logic [WIDTH-1:0]  o_quad_data,
    output logic              o_valid,
    output logic [RATE_W-1:0] o_phase
);

    // Same layout as iq_sample_t, but sized by this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] inph;
        logic [WIDTH-1:0] quad;
    } sample_t;

    sample_t           sample_q, sample_d;
    logic              valid_q, valid_d;
    logic [RATE_W-1:0] phase;

    cic_phase_counter #(
        .MAX_RATE (MAX_RATE)
    ) u_phase (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_rate   (i_rate),
        .o_phase  (phase),
        .o_wrap   (o_comb_ready)
    );

    always_comb begin
        sample_d = sample_q;
        valid_d  = i_enable;
        if (i_enable) begin
            // The comb updated on the previous wrap, so phase 0 sees the fresh sample.
            if (phase == '0) begin
                sample_d.inph = i_inph_data;
                sample_d.quad = i_quad_data;
            end else if (HOLD_MODE == 0) begin
                sample_d = '0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign o_inph_data = sample_q.inph;
    assign o_quad_data = sample_q.quad;
    assign o_valid     = valid_q;
    assign o_phase     = phase;

endmodule

// File: tb/tb_cic_interp_upsample.sv
// Directed bench for cic_interp_upsample: zero-stuff and hold instances share one stimulus stream.
module tb_cic_interp_upsample;
    import cic_interp_pkg::*;

    localparam int W  = 16;
    localparam int MR = 16;
    localparam int RW = $clog2(MR + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en;
    logic [RW-1:0] rate;
    iq_sample_t    stim;

    logic          rdy0, rdy1, v0, v1;
    logic [W-1:0]  i0, q0, i1, q1;
    logic [RW-1:0] ph0, ph1;

    cic_interp_upsample #(.WIDTH(W), .MAX_RATE(MR), .HOLD_MODE(0)) dut0 (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_rate       (rate),
        .o_comb_ready (rdy0),
        .i_inph_data  (stim.inph),
        .i_quad_data  (stim.quad),
        .o_inph_data  (i0),
        .o_quad_data  (q0),
        .o_valid      (v0),
        .o_phase      (ph0)
    );

    cic_interp_upsample #(.WIDTH(W), .MAX_RATE(MR), .HOLD_MODE(1)) dut1 (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_rate       (rate),
        .o_comb_ready (rdy1),
        .i_inph_data  (stim.inph),
        .i_quad_data  (stim.quad),
        .o_inph_data  (i1),
        .o_quad_data  (q1),
        .o_valid      (v1),
        .o_phase      (ph1)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic [RW-1:0] rate;
        logic [W-1:0]  din;
        logic          rdy;
        logic [RW-1:0] ph;
        logic [W-1:0]  d0;
        logic [W-1:0]  d1;
        logic          vld;
        logic          chk;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int r, input int e, input int rt, input int din,
                                input int rdy, input int ph, input int d0, input int d1,
                                input int vld, input int chk);
        vec_t v;
        v.rst  = (r != 0);
        v.en   = (e != 0);
        v.rate = RW'(rt);
        v.din  = W'(din);
        v.rdy  = (rdy != 0);
        v.ph   = RW'(ph);
        v.d0   = W'(d0);
        v.d1   = W'(d1);
        v.vld  = (vld != 0);
        v.chk  = (chk != 0);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    initial begin
        // rst en rate din | rdy ph d0(zero-stuff) d1(hold) vld chk
        // Rate 4 with a comb ramp advanced on each ready strobe.
        tbl.push_back(mk(1, 1, 4, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4, 0,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4, 0,  0, 2, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4, 0,  1, 3, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4, 1,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4, 1,  0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4, 1,  0, 2, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4, 1,  1, 3, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4, 2,  0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4, 2,  0, 1, 2, 2, 1, 1));
        tbl.push_back(mk(0, 1, 4, 2,  0, 2, 0, 2, 1, 1));
        tbl.push_back(mk(0, 1, 4, 2,  1, 3, 0, 2, 1, 1));
        // Rate 3, comb 10 then 20: hold instance gives 10,10,10,20,20,20.
        tbl.push_back(mk(1, 1, 3, 10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 10, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3, 10, 0, 1, 10, 10, 1, 1));
        tbl.push_back(mk(0, 1, 3, 10, 1, 2, 0, 10, 1, 1));
        tbl.push_back(mk(0, 1, 3, 20, 0, 0, 0, 10, 1, 1));
        tbl.push_back(mk(0, 1, 3, 20, 0, 1, 20, 20, 1, 1));
        tbl.push_back(mk(0, 1, 3, 20, 1, 2, 0, 20, 1, 1));
        tbl.push_back(mk(0, 1, 3, 20, 0, 0, 0, 20, 1, 1));
        // Rate 4 -> 2 requested at phase 1: current frame finishes at length 4.
        tbl.push_back(mk(1, 1, 4, 5,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4, 5,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2, 5,  0, 1, 5, 5, 1, 1));
        tbl.push_back(mk(0, 1, 2, 5,  0, 2, 0, 5, 1, 1));
        tbl.push_back(mk(0, 1, 2, 5,  1, 3, 0, 5, 1, 1));
        tbl.push_back(mk(0, 1, 2, 5,  0, 0, 0, 5, 1, 1));
        tbl.push_back(mk(0, 1, 2, 5,  1, 1, 5, 5, 1, 1));
        tbl.push_back(mk(0, 1, 2, 5,  0, 0, 0, 5, 1, 1));
        // Rate 2 with enable toggling 1,0,1,0.
        tbl.push_back(mk(1, 1, 2, 3,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 3,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2, 3,  0, 1, 3, 3, 1, 1));
        tbl.push_back(mk(0, 1, 2, 3,  1, 1, 3, 3, 0, 1));
        tbl.push_back(mk(0, 0, 2, 3,  0, 0, 0, 3, 1, 1));
        tbl.push_back(mk(0, 1, 2, 3,  0, 0, 0, 3, 0, 1));
        tbl.push_back(mk(0, 1, 2, 3,  1, 1, 3, 3, 1, 1));
        // Rate 0 sanitises to pass-through.
        tbl.push_back(mk(1, 1, 0, 11, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 11, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 12, 1, 0, 11, 11, 1, 1));
        tbl.push_back(mk(0, 1, 0, 13, 1, 0, 12, 12, 1, 1));
        tbl.push_back(mk(0, 1, 0, 13, 1, 0, 13, 13, 1, 1));
        // Reset mid-frame at phase 2, then reset landing on the wrap phase.
        tbl.push_back(mk(1, 1, 4, 7,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4, 7,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4, 7,  0, 1, 7, 7, 1, 1));
        tbl.push_back(mk(1, 1, 4, 7,  0, 2, 0, 7, 1, 1));
        tbl.push_back(mk(0, 1, 4, 7,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4, 7,  0, 1, 7, 7, 1, 1));
        tbl.push_back(mk(0, 1, 4, 7,  0, 2, 0, 7, 1, 1));
        tbl.push_back(mk(1, 1, 4, 7,  0, 3, 0, 7, 1, 1));
        tbl.push_back(mk(0, 1, 4, 7,  0, 0, 0, 0, 0, 1));

        foreach (tbl[k]) begin
            rst       = tbl[k].rst;
            en        = tbl[k].en;
            rate      = tbl[k].rate;
            stim.inph = tbl[k].din;
            stim.quad = W'(tbl[k].din << 1);
            #1;
            check($sformatf("row%0d ready_zs", k), int'(rdy0), int'(tbl[k].rdy));
            check($sformatf("row%0d ready_hold", k), int'(rdy1), int'(tbl[k].rdy));
            if (tbl[k].chk) begin
                check($sformatf("row%0d phase_zs", k), int'(ph0), int'(tbl[k].ph));
                check($sformatf("row%0d phase_hold", k), int'(ph1), int'(tbl[k].ph));
                check($sformatf("row%0d inph_zs", k), int'(i0), int'(tbl[k].d0));
                check($sformatf("row%0d quad_zs", k), int'(q0), int'(W'(tbl[k].d0 << 1)));
                check($sformatf("row%0d inph_hold", k), int'(i1), int'(tbl[k].d1));
                check($sformatf("row%0d quad_hold", k), int'(q1), int'(W'(tbl[k].d1 << 1)));
                check($sformatf("row%0d valid_zs", k), int'(v0), int'(tbl[k].vld));
                check($sformatf("row%0d valid_hold", k), int'(v1), int'(tbl[k].vld));
            end
            @(posedge clk);
            #1;
        end

        // Over-range rate clamps to MAX_RATE: ready once every 16 enabled cycles.
        rst  = 1'b1;
        en   = 1'b1;
        rate = RW'(MR + 5);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2 * MR + 1; i++) begin
            #1;
            check($sformatf("clamp%0d phase", i), int'(ph0), i % MR);
            check($sformatf("clamp%0d ready", i), int'(rdy0), ((i % MR) == MR - 1) ? 1 : 0);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
